// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package pipeline_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data-port grants won while fetch was waiting.
module arb_starve_cnt #(
    parameter int unsigned MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !sat_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat_o = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports,
// one transaction at a time, with data-port priority and a fetch starvation guard.
module mem_port_arbiter
    import pipeline_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT       = 2,
    parameter int unsigned IF_STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_owner_t       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_if_hold;
    logic [31:0]      r_dm_hold;

    logic w_starve_sat;
    logic w_if_win;
    logic w_dm_win;
    logic w_resp;
    logic w_if_resp;
    logic w_dm_resp;

    // Fetch only beats a competing data request once the guard has saturated.
    assign w_if_win  = (r_state == IDLE) && if_req_i && (!dm_req_i || w_starve_sat);
    assign w_dm_win  = (r_state == IDLE) && dm_req_i && !w_if_win;
    assign w_resp    = (r_state == WAIT) && (r_cnt == CNT_W'(MEM_LAT));
    assign w_if_resp = w_resp && (r_owner == OWN_IF);
    assign w_dm_resp = w_resp && (r_owner == OWN_DM);

    arb_starve_cnt #(
        .MAX(IF_STARVE_MAX)
    ) u_starve_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(w_dm_win && if_req_i),
        .clr_i(w_if_win),
        .sat_o(w_starve_sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (if_req_i || dm_req_i) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_resp) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner   <= OWN_IF;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_if_hold <= '0;
            r_dm_hold <= '0;
        end else begin
            if (w_if_win) begin
                r_owner <= OWN_IF;
                r_we    <= 1'b0;
                r_addr  <= if_addr_i & WORD_MASK;
                r_wdata <= '0;
            end else if (w_dm_win) begin
                r_owner <= OWN_DM;
                r_we    <= dm_we_i;
                r_addr  <= dm_addr_i & WORD_MASK;
                r_wdata <= dm_wdata_i;
            end
            if (r_state == ISSUE) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == WAIT) begin
                r_cnt <= w_resp ? '0 : r_cnt + 1'b1;
            end
            if (w_if_resp) r_if_hold <= mem_rdata_i;
            // Store completions carry no data, so the load hold value survives them.
            if (w_dm_resp && !r_we) r_dm_hold <= mem_rdata_i;
        end
    end

    always_comb begin
        if_gnt_o    = w_if_win;
        dm_gnt_o    = w_dm_win;
        if_rvalid_o = w_if_resp;
        dm_rvalid_o = w_dm_resp;
        if_rdata_o  = w_if_resp ? mem_rdata_i : r_if_hold;
        dm_rdata_o  = w_dm_resp ? mem_rdata_i : r_dm_hold;
        stall_if_o  = if_req_i && !w_if_resp;
        stall_mem_o = dm_req_i && !w_dm_resp;
        mem_en_o    = (r_state == ISSUE);
        mem_we_o    = (r_state == ISSUE) && r_we;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences and
// randomized traffic against a transaction-level schedule model.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic        stall_if_o, stall_mem_o, mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_LAT(MEM_LAT),
        .IF_STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Memory macro model: fixed latency, garbage on the bus outside response slots.
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem [0:255];
    logic [31:0] pipe [0:MEM_LAT-1];
    logic        mem_load = 1'b0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_en_o && mem_we_o) begin
            mem[mem_addr_o[9:2]] <= mem_wdata_o;
        end
        pipe[0] <= (mem_en_o && !mem_we_o) ? mem[mem_addr_o[9:2]] : $urandom;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_i = pipe[MEM_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [5:0]  ctl;       // {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid}
        logic [1:0]  stl;       // {stall_if, stall_mem}
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] if_rdata;
        logic [31:0] dm_rdata;
        logic        chk_dm;
    } vec_t;

    localparam logic [31:0] F = 32'h0020_0093;
    localparam logic [31:0] D = 32'hDEAD_BEEF;

    vec_t        tv [0:14];
    logic [5:0]  got_order;
    logic [5:0]  exp_order;
    int          ngr, both;
    logic        seen;

    // Reference-model state for the random phase.
    int          cmd_at, resp_at, free_at, starve;
    logic        m_own_dm, m_we, if_done, dm_done;
    logic [31:0] m_addr, m_wdata, m_rdata, if_hold, dm_hold, e_ifd;
    logic        e_ig, e_dg, e_en, e_we, e_iv, e_dv;

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        ref_mem[4] = F;
        ref_mem[8] = 32'h1234_5678;

        tv[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 2'b00, 32'h0,   32'h0, 32'h0, 32'h0, 1'b1};
        tv[1]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0, 6'b100000, 2'b10, 32'h0,   32'h0, 32'h0, 32'h0, 1'b1};
        tv[2]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0, 6'b001000, 2'b10, 32'h10,  32'h0, 32'h0, 32'h0, 1'b1};
        tv[3]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 2'b10, 32'h10,  32'h0, 32'h0, 32'h0, 1'b1};
        tv[4]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000010, 2'b00, 32'h10,  32'h0, F,     32'h0, 1'b1};
        tv[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 2'b00, 32'h10,  32'h0, F,     32'h0, 1'b1};
        tv[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h106, D,     6'b010000, 2'b01, 32'h10,  32'h0, F,     32'h0, 1'b1};
        tv[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h106, D,     6'b001100, 2'b01, 32'h104, D,     F,     32'h0, 1'b1};
        tv[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h106, D,     6'b000000, 2'b01, 32'h104, D,     F,     32'h0, 1'b1};
        tv[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h106, D,     6'b000001, 2'b00, 32'h104, D,     F,     32'h0, 1'b0};
        tv[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0, 6'b010000, 2'b01, 32'h104, D,     F,     32'h0, 1'b1};
        tv[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0, 6'b001000, 2'b01, 32'h104, 32'h0, F,     32'h0, 1'b1};
        tv[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0, 6'b000000, 2'b01, 32'h104, 32'h0, F,     32'h0, 1'b1};
        tv[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0, 6'b000001, 2'b00, 32'h104, 32'h0, F,     D,     1'b1};
        tv[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 2'b00, 32'h104, 32'h0, F,     D,     1'b1};

        rst = 1'b1; mem_load = 1'b1; idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0; mem_load = 1'b0;

        // Directed vectors: reset state, single fetch, store then load.
        for (int i = 0; i < 15; i++) begin
            if_req = tv[i].if_req; if_addr = tv[i].if_addr; dm_req = tv[i].dm_req;
            dm_we = tv[i].dm_we; dm_addr = tv[i].dm_addr; dm_wdata = tv[i].dm_wdata;
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'({if_gnt_o, dm_gnt_o, mem_en_o, mem_we_o,
                if_rvalid_o, dm_rvalid_o}), 32'(tv[i].ctl));
            chk($sformatf("vec%0d_stall", i), 32'({stall_if_o, stall_mem_o}), 32'(tv[i].stl));
            chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, tv[i].mem_addr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata_o, tv[i].mem_wdata);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata_o, tv[i].if_rdata);
            if (tv[i].chk_dm) chk($sformatf("vec%0d_dm_rdata", i), dm_rdata_o, tv[i].dm_rdata);
            @(negedge clk);
        end

        // Conflict: both ports request continuously.
        if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        ngr = 0; both = 0; got_order = '0; exp_order = 6'b110110;
        for (int c = 0; c < 60 && ngr < 6; c++) begin
            #1;
            if (if_gnt_o && dm_gnt_o) both++;
            if (if_gnt_o || dm_gnt_o) begin
                got_order[5-ngr] = dm_gnt_o;
                ngr++;
            end
            @(negedge clk);
        end
        chk("conflict_grant_count", 32'(ngr), 32'd6);
        chk("conflict_order_dm1_is1", 32'(got_order), 32'(exp_order));
        chk("conflict_dual_grant", 32'(both), 32'd0);
        idle_inputs();
        repeat (6) @(negedge clk);

        // Hold register after a fetch response.
        if_req = 1'b1; if_addr = 32'h20; seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (if_rvalid_o) begin
                seen = 1'b1;
                chk("hold_resp_data", if_rdata_o, 32'h1234_5678);
            end else begin
                @(negedge clk);
            end
        end
        chk("hold_resp_seen", 32'(seen), 32'd1);
        @(negedge clk);
        if_req = 1'b0; #1;
        chk("hold_rdata_after_drop", if_rdata_o, 32'h1234_5678);
        chk("hold_no_rvalid", 32'(if_rvalid_o), 32'd0);
        repeat (2) @(negedge clk);
        #1 chk("hold_rdata_later", if_rdata_o, 32'h1234_5678);
        @(negedge clk);

        // Reset one cycle after ISSUE.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h5555_AAAA;
        #1 chk("rst_seq_gnt", 32'(dm_gnt_o), 32'd1);
        @(negedge clk); #1 chk("rst_seq_issue", 32'(mem_en_o), 32'd1);
        @(negedge clk); rst = 1'b1; idle_inputs();
        #1 chk("rst_seq_wait_rvalid", 32'(dm_rvalid_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_out_ctl", 32'({if_gnt_o, dm_gnt_o, mem_en_o, mem_we_o, if_rvalid_o, dm_rvalid_o,
            stall_if_o, stall_mem_o}), 32'd0);
        chk("rst_out_mem_addr", mem_addr_o, 32'h0);
        chk("rst_out_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_out_if_rdata", if_rdata_o, 32'h0);
        chk("rst_out_dm_rdata", dm_rdata_o, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (if_rvalid_o || dm_rvalid_o) seen = 1'b1;
        end
        chk("rst_no_late_rvalid", 32'(seen), 32'd0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1 chk("post_rst_gnt", 32'(if_gnt_o), 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("post_rst_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("post_rst_rdata", if_rdata_o, F);
        @(negedge clk); idle_inputs();
        @(negedge clk);

        // Request dropped the cycle after its grant.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        #1 chk("drop_gnt", 32'(dm_gnt_o), 32'd1);
        @(negedge clk); dm_req = 1'b0;
        #1 chk("drop_t1_rvalid", 32'(dm_rvalid_o), 32'd0);
        @(negedge clk); #1 chk("drop_t2_rvalid", 32'(dm_rvalid_o), 32'd0);
        chk("drop_t2_stall", 32'(stall_mem_o), 32'd0);
        @(negedge clk); #1 chk("drop_t3_rvalid", 32'(dm_rvalid_o), 32'd1);
        chk("drop_t3_rdata", dm_rdata_o, ref_mem[32]);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1 chk("drop_idle_regrant", 32'(if_gnt_o), 32'd1);
        repeat (4) @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Randomized traffic against the schedule model.
        rst = 1'b1; mem_load = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_load = 1'b0;
        cmd_at = -1; resp_at = -1; free_at = 0; starve = 0;
        m_own_dm = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        if_hold = '0; dm_hold = '0; if_done = 1'b0; dm_done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (!if_req || if_done) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 1023));
            end
            if (!dm_req || dm_done) begin
                dm_req = ($urandom_range(0, 2) != 0);
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'($urandom_range(0, 1023));
                dm_wdata = $urandom;
            end
            if_done = 1'b0; dm_done = 1'b0;
            e_en = (t == cmd_at);
            e_we = e_en && m_we;
            e_iv = (t == resp_at) && !m_own_dm;
            e_dv = (t == resp_at) && m_own_dm;
            e_ig = 1'b0; e_dg = 1'b0;
            if (t >= free_at && (if_req || dm_req)) begin
                e_ig = if_req && (!dm_req || starve == STARVE_MAX);
                e_dg = !e_ig;
            end
            #1;
            chk($sformatf("rnd%0d_ctl", t), 32'({if_gnt_o, dm_gnt_o, mem_en_o, mem_we_o,
                if_rvalid_o, dm_rvalid_o}), 32'({e_ig, e_dg, e_en, e_we, e_iv, e_dv}));
            chk($sformatf("rnd%0d_stall", t), 32'({stall_if_o, stall_mem_o}),
                32'({if_req && !e_iv, dm_req && !e_dv}));
            chk($sformatf("rnd%0d_mem_addr", t), mem_addr_o, m_addr);
            if (e_we) chk($sformatf("rnd%0d_mem_wdata", t), mem_wdata_o, m_wdata);
            e_ifd = e_iv ? m_rdata : if_hold;
            chk($sformatf("rnd%0d_if_rdata", t), if_rdata_o, e_ifd);
            if (!(e_dv && m_we)) begin
                chk($sformatf("rnd%0d_dm_rdata", t), dm_rdata_o, e_dv ? m_rdata : dm_hold);
            end
            if (e_iv) begin if_hold = m_rdata; if_done = 1'b1; end
            if (e_dv) begin
                if (!m_we) dm_hold = m_rdata;
                dm_done = 1'b1;
            end
            if (e_ig || e_dg) begin
                if (e_ig) starve = 0;
                else if (if_req && starve < STARVE_MAX) starve++;
                m_own_dm = e_dg;
                m_we     = e_dg && dm_we;
                m_addr   = (e_dg ? dm_addr : if_addr) & 32'hFFFF_FFFC;
                m_wdata  = e_dg ? dm_wdata : 32'h0;
                if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
                else      m_rdata = ref_mem[m_addr[9:2]];
                cmd_at  = t + 1;
                resp_at = t + 1 + MEM_LAT;
                free_at = t + 2 + MEM_LAT;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It accepts one request at a time, issues the command, waits out the memory latency, returns the response to the owning requester and drives per-port stall signals. When both ports compete, the data port wins, with a starvation guard that protects fetch. It sits between the pipeline's IF/MEM stages and the memory macro, replacing separate instruction and data memories.

## Interface
- MEM_LAT, 2, cycles from the command cycle to valid `mem_rdata_i` (≥1)
- IF_STARVE_MAX, 4, consecutive DM grants won against a waiting IF before IF is forced (≥1)
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request (level; held until `if_rvalid_o`)
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response this cycle
- if_rdata_o  out  32  fetch data
- dm_req_i  in  1  data request (level; held until `dm_rvalid_o`)
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  store data
- dm_gnt_o  out  1  data request accepted this cycle
- dm_rvalid_o  out  1  load data / store completion this cycle
- dm_rdata_o  out  32  load data
- stall_if_o  out  1  `if_req_i & ~if_rvalid_o`
- stall_mem_o  out  1  `dm_req_i & ~dm_rvalid_o`
- mem_en_o  out  1  memory command strobe (one cycle)
- mem_we_o  out  1  memory write enable (with `mem_en_o`)
- mem_addr_o  out  32  word-aligned address, `{addr[31:2],2'b00}`
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid MEM_LAT cycles after the command cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT. Owner register: IF or DM.
- IDLE: if any request is pending, assert the winner's `*_gnt_o` (combinational) and latch its owner, we, address and wdata. The next state is ISSUE. With no request, stay in IDLE. IF `we` is always 0.
- Arbitration when only one port requests: that port wins. When both request: DM wins, unless the starvation count equals IF_STARVE_MAX, in which case IF wins.
- Starvation count: increments on a DM grant while `if_req_i` is high, saturating at IF_STARVE_MAX. It clears on any IF grant.
- ISSUE: one cycle. `mem_en_o`=1 and `mem_we_o`/`mem_addr_o`/`mem_wdata_o` come from the latched registers. The next state is WAIT with count=1.
- WAIT: the count increments each cycle. When count==MEM_LAT, this is the response cycle:
  - the owner's `*_rvalid_o` is 1;
  - `*_rdata_o` = `mem_rdata_i`, which is also captured into the owner's hold register;
  - the next state is IDLE.
- Response data for stores: `dm_rvalid_o` still pulses. `dm_rdata_o` is don't-care, and the hold register is not updated.
- Outside the response cycle, `*_rdata_o` = that port's hold register.
- `mem_addr_o`/`mem_wdata_o` hold the latched values outside ISSUE. `mem_en_o`/`mem_we_o` are 0 outside ISSUE.
- Requester inputs are ignored after grant. A request dropped mid-transaction still completes, and its response pulse is ignored by the requester.
- A request still high in the cycle after its `rvalid` is a new request.

## Timing
- Grant in cycle t, command in t+1, response in t+1+MEM_LAT. The earliest next grant is t+2+MEM_LAT.
- Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Stalls are combinational from the requests and rvalid. A requesting port stalls from its request cycle through the cycle before its rvalid.
- Reset (any state, including mid-WAIT) has effect from the next edge:
  - FSM returns to IDLE; count, owner and starvation count are 0;
  - all latched registers and hold registers are 0;
  - the in-flight response is discarded, with no rvalid.
- All outputs are 0 during and after reset until a request arrives.
- Simultaneous requests in IDLE: exactly one grant.
- Count width: ⌈log2(MEM_LAT+1)⌉. Starvation count width: ⌈log2(IF_STARVE_MAX+1)⌉.

## Structure
- The shared package `pipeline_mem_pkg` holds:
  - the `arb_state_t` enum (IDLE, ISSUE, WAIT);
  - the `arb_owner_t` enum (OWN_IF, OWN_DM);
  - the constant `WORD_MASK` = 32'hFFFF_FFFC.
- One optional sub-module, `arb_starve_cnt`: a saturating counter with inc/clr/sat outputs. Everything else lives in one module.

## Test plan
All scenarios use MEM_LAT=2 and IF_STARVE_MAX=2.
- Single fetch: `if_req_i`=1, `if_addr_i`=0x0000_0010, memory word 0x0010 = 0x0020_0093 -> `if_gnt_o` at t, `mem_en_o`/`mem_addr_o`=0x10 at t+1, `if_rvalid_o` and `if_rdata_o`=0x0020_0093 at t+3. `stall_if_o`=1 for t..t+2.
- Store then load: store 0xDEAD_BEEF to 0x0000_0104 (addr[1:0] ignored), then load 0x104 -> `mem_we_o`=1 only in the store's ISSUE cycle. `dm_rdata_o`=0xDEAD_BEEF at the load's response cycle and is held afterwards.
- Conflict: IF and DM both request continuously -> grant order DM, DM, IF, DM, DM, IF. No cycle has both grants.
- Hold register: after a fetch returns 0x1234_5678, drop `if_req_i` -> `if_rdata_o` stays 0x1234_5678 and `if_rvalid_o`=0.
- Reset mid-WAIT: assert `rst_i` one cycle after ISSUE -> no rvalid pulses. All outputs are 0 the cycle after the reset edge. The first request after reset is granted immediately.
- Dropped request: drop `dm_req_i` the cycle after `dm_gnt_o` -> the transaction completes, `dm_rvalid_o` pulses at t+3, and the FSM returns to IDLE.
